demux_reg: RTL and testbench
============================

Name: demux_reg

Overview:
- 1-to-10 write demultiplexer with a holding register bank. It is the write-side counterpart of the 10:1 16-bit read mux.
- Accepts a 16-bit word through a valid/ready handshake and stores it in one of ten output registers.
- The target register is either an explicit 4-bit select or an internal auto-increment pointer.
- Tracks which registers hold data, and provides fill status and back-pressure to the producer.

Parameters:
- WIDTH, 16, data width of the input and of each output register.
- WRAP, 0, auto mode when all ten registers hold data: 0 = stall (in_ready low); 1 = pointer wraps and overwrites.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to store.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word this cycle.
- demux_sel  input  4  target index in manual mode; valid range 0..9.
- auto_inc  input  1  1 = target is wr_ptr; 0 = target is demux_sel.
- clear  input  1  synchronous clear of the bank and status.
- out_0 .. out_9  output  WIDTH each  stored registers.
- out_valid  output  10  bit N set once out_N has been written since reset or clear.
- all_written  output  1  equals &out_valid.
- wr_ptr  output  4  auto-increment pointer, 0..9.
- sel_err  output  1  one-cycle pulse on a manual write with demux_sel > 9.

Behaviour:
- Reset (async, immediate): out_0..out_9 = 0, out_valid = 0, wr_ptr = 0, all_written = 0, sel_err = 0, state = EMPTY. in_ready reflects the reset state (1).
- Handshake: a transfer occurs on a rising clk edge when in_valid & in_ready.
  - The target register updates on that edge, so the stored value is visible the next cycle (latency 1).
  - in_data and demux_sel are sampled only on a transfer.
- Target index = auto_inc ? wr_ptr : demux_sel, evaluated in the transfer cycle.
- Index 0..9: out_idx <= in_data and out_valid[idx] <= 1. Rewriting an already-valid register overwrites it; out_valid stays 1.
- Manual index 10..15: the transfer completes (accept-and-drop). No register changes. sel_err = 1 for exactly the next cycle.
- wr_ptr:
  - Increments by 1 on each auto-mode transfer and wraps 9 -> 0.
  - Unchanged by manual transfers.
  - Never takes values above 9.
- State machine, based on the popcount of out_valid:
  - EMPTY (0 valid) -> PARTIAL on the first successful write.
  - PARTIAL -> FULL when the last invalid bit is set.
  - Any state -> EMPTY on clear.
  - FULL is left only by clear or rst.
  - all_written = 1 exactly in FULL.
- in_ready is combinational from registered state and inputs:
  - 0 when clear = 1.
  - 0 when state = FULL and auto_inc = 1 and WRAP = 0.
  - 1 otherwise.
  - Manual writes in FULL are always accepted.
- clear (sync, rising edge): all out_N = 0, out_valid = 0, wr_ptr = 0, sel_err = 0, state = EMPTY. Because in_ready is 0 in the clear cycle, no transfer is lost.
- Switching auto_inc between cycles is legal. The pointer keeps its value across manual writes.
- rst asserted mid-transfer: the transfer is discarded and all state goes to reset values. The first transfer can occur on the first rising edge after rst deasserts.

Test Plan:
- Reset, then auto_inc = 1 with ten back-to-back transfers 16'h1000..16'h1009 -> out_N = 16'h1000+N, wr_ptr returns to 0, out_valid = 10'h3FF, all_written rises the cycle after the 10th transfer.
- WRAP = 0: after a full fill, hold in_valid = 1 with auto_inc = 1 -> in_ready = 0 and outputs unchanged. Drop auto_inc, demux_sel = 3, in_data = 16'hBEEF -> transfer completes, out_3 = 16'hBEEF next cycle.
- WRAP = 1: full fill, then an 11th auto write of 16'hAAAA -> in_ready stays 1, out_0 = 16'hAAAA, wr_ptr = 1, all_written stays 1.
- Manual demux_sel = 12, in_data = 16'h5555 -> in_ready = 1, sel_err high for one cycle, all out_N and out_valid unchanged.
- Assert clear and in_valid together in PARTIAL state -> in_ready = 0, no write; next cycle all out_N = 0, out_valid = 0, wr_ptr = 0, state EMPTY.
- Assert rst asynchronously between clock edges after five auto writes -> outputs go to 0 immediately without a clock edge. After release, the first auto write lands in out_0.

Source files
------------

// File: rtl/demux_reg.sv
// 1-to-10 write demultiplexer: a valid/ready word is stored into one of ten registers, chosen by demux_sel or an auto-increment pointer.
// Latency 1 (stored value visible the cycle after the transfer); in_ready drops during clear and, if WRAP == 0, for auto writes once all ten are filled.
module demux_reg #(
    parameter int WIDTH = 16,
    parameter int WRAP  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       demux_sel,
    input  logic             auto_inc,
    input  logic             clear,
    output logic [WIDTH-1:0] out_0,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_3,
    output logic [WIDTH-1:0] out_4,
    output logic [WIDTH-1:0] out_5,
    output logic [WIDTH-1:0] out_6,
    output logic [WIDTH-1:0] out_7,
    output logic [WIDTH-1:0] out_8,
    output logic [WIDTH-1:0] out_9,
    output logic [9:0]       out_valid,
    output logic             all_written,
    output logic [3:0]       wr_ptr,
    output logic             sel_err
);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] bank_q [10];
    logic [9:0]       valid_q, valid_d;
    logic [3:0]       ptr_q, ptr_d, tgt;
    logic             err_q, err_d, full_q;
    logic             xfer, hit;

    always_comb begin
        tgt      = auto_inc ? ptr_q : demux_sel;
        in_ready = !clear && !(state_q == FULL && auto_inc && WRAP == 0);
        xfer     = in_valid && in_ready;
        hit      = xfer && (tgt < 4'd10);
        // Out-of-range manual selects are accepted and dropped, flagged for one cycle.
        err_d    = xfer && !auto_inc && (demux_sel > 4'd9);
        valid_d  = valid_q;
        if (hit) begin
            valid_d = valid_q | (10'd1 << tgt);
        end
        ptr_d = ptr_q;
        if (xfer && auto_inc) begin
            ptr_d = (ptr_q == 4'd9) ? 4'd0 : ptr_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            full_q  <= 1'b0;
            valid_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                bank_q[i] <= '0;
            end
        end else if (clear) begin
            state_q <= EMPTY;
            full_q  <= 1'b0;
            valid_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            for (int i = 0; i < 10; i++) begin
                if (hit && tgt == 4'(i)) begin
                    bank_q[i] <= in_data;
                end
            end
            case (state_q)
                EMPTY: begin
                    if (hit) begin
                        state_q <= (&valid_d) ? FULL : PARTIAL;
                        full_q  <= &valid_d;
                    end
                end
                PARTIAL: begin
                    if (&valid_d) begin
                        state_q <= FULL;
                        full_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FULL;
                    full_q  <= 1'b1;
                end
            endcase
        end
    end

    assign out_0       = bank_q[0];
    assign out_1       = bank_q[1];
    assign out_2       = bank_q[2];
    assign out_3       = bank_q[3];
    assign out_4       = bank_q[4];
    assign out_5       = bank_q[5];
    assign out_6       = bank_q[6];
    assign out_7       = bank_q[7];
    assign out_8       = bank_q[8];
    assign out_9       = bank_q[9];
    assign out_valid   = valid_q;
    assign all_written = full_q;
    assign wr_ptr      = ptr_q;
    assign sel_err     = err_q;

endmodule

// File: tb/tb_demux_reg.sv
// Drives a WRAP=0 and a WRAP=1 instance with the same stimulus and compares both against
// a per-instance array model of the register bank, pointer and status.
module tb_demux_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid, auto_inc, clear;
    logic [3:0]  demux_sel;

    logic        rdy [2];
    logic [15:0] dq  [2][10];
    logic [9:0]  ov  [2];
    logic        aw  [2];
    logic [3:0]  wp  [2];
    logic        se  [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mreg [2][10];
    logic [9:0]  mval [2];
    int          mptr [2];
    bit          merr [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        demux_reg #(.WIDTH(16), .WRAP(g)) u_dut (
            .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
            .in_ready(rdy[g]), .demux_sel(demux_sel), .auto_inc(auto_inc), .clear(clear),
            .out_0(dq[g][0]), .out_1(dq[g][1]), .out_2(dq[g][2]), .out_3(dq[g][3]),
            .out_4(dq[g][4]), .out_5(dq[g][5]), .out_6(dq[g][6]), .out_7(dq[g][7]),
            .out_8(dq[g][8]), .out_9(dq[g][9]), .out_valid(ov[g]), .all_written(aw[g]),
            .wr_ptr(wp[g]), .sel_err(se[g])
        );
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function bit mrdy(input int k);
        return !clear && !(mval[k] == 10'h3FF && auto_inc && k == 0);
    endfunction

    task mreset(input int k);
        for (int i = 0; i < 10; i++) mreg[k][i] = 16'h0;
        mval[k] = '0;
        mptr[k] = 0;
        merr[k] = 1'b0;
    endtask

    task model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst || clear) begin
                mreset(k);
            end else begin
                bit x;
                int idx;
                x = in_valid && mrdy(k);
                merr[k] = 1'b0;
                if (x) begin
                    idx = auto_inc ? mptr[k] : int'(demux_sel);
                    if (idx < 10) begin
                        mreg[k][idx] = in_data;
                        mval[k][idx] = 1'b1;
                    end else begin
                        merr[k] = 1'b1;
                    end
                    if (auto_inc) mptr[k] = (mptr[k] + 1) % 10;
                end
            end
        end
    endtask

    task check_all();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++)
                check($sformatf("u%0d.out_%0d", k, i), 32'(dq[k][i]), 32'(mreg[k][i]));
            check($sformatf("u%0d.out_valid", k), 32'(ov[k]), 32'(mval[k]));
            check($sformatf("u%0d.all_written", k), 32'(aw[k]), 32'($countones(mval[k]) == 10));
            check($sformatf("u%0d.wr_ptr", k), 32'(wp[k]), 32'(mptr[k]));
            check($sformatf("u%0d.sel_err", k), 32'(se[k]), 32'(merr[k]));
        end
    endtask

    task drive(input logic v, input logic a, input logic [3:0] s, input logic [15:0] d, input logic c);
        in_valid  = v;
        auto_inc  = a;
        demux_sel = s;
        in_data   = d;
        clear     = c;
    endtask

    task step();
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("u%0d.in_ready", k), 32'(rdy[k]), 32'(mrdy(k)));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 4'd0, 16'h0, 0);
        mreset(0);
        mreset(1);
        #12;
        check("rst_ready", 32'(rdy[0]), 32'd1);
        check_all();
        rst = 1'b0;

        // Sequential auto fill 0x1000..0x1009.
        for (int n = 0; n < 10; n++) begin
            drive(1, 1, 4'd0, 16'h1000 + 16'(n), 0);
            step();
            if (n == 8) check("aw_before_last", 32'(aw[0]), 32'd0);
        end
        check("fill_out9", 32'(dq[0][9]), 32'h1009);
        check("fill_valid", 32'(ov[0]), 32'h3FF);
        check("fill_ptr", 32'(wp[0]), 32'd0);
        check("fill_aw", 32'(aw[0]), 32'd1);

        // Auto write when full: stalls without wrap, overwrites out_0 with wrap.
        drive(1, 1, 4'd0, 16'hAAAA, 0);
        step();
        check("nowrap_out0", 32'(dq[0][0]), 32'h1000);
        check("wrap_out0", 32'(dq[1][0]), 32'hAAAA);
        check("wrap_ptr", 32'(wp[1]), 32'd1);
        check("wrap_aw", 32'(aw[1]), 32'd1);

        drive(1, 0, 4'd3, 16'hBEEF, 0);
        step();
        check("manual_full_out3", 32'(dq[0][3]), 32'hBEEF);

        drive(1, 0, 4'd12, 16'h5555, 0);
        step();
        check("bad_sel_err", 32'(se[0]), 32'd1);
        drive(0, 0, 4'd0, 16'h0, 0);
        step();
        check("bad_sel_err_drop", 32'(se[0]), 32'd0);

        // Clear, partial fill, then clear together with a valid word.
        drive(0, 0, 4'd0, 16'h0, 1);
        step();
        for (int n = 0; n < 3; n++) begin
            drive(1, 1, 4'd0, 16'h4000 + 16'(n), 0);
            step();
        end
        drive(1, 1, 4'd0, 16'h7777, 1);
        step();
        check("clear_valid", 32'(ov[0]), 32'd0);
        check("clear_ptr", 32'(wp[0]), 32'd0);

        repeat (400) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  4'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom_range(0, 39) == 0));
            step();
        end

        // Asynchronous reset after five auto writes, between clock edges.
        drive(0, 0, 4'd0, 16'h0, 1);
        step();
        for (int n = 0; n < 5; n++) begin
            drive(1, 1, 4'd0, 16'h2000 + 16'(n), 0);
            step();
        end
        drive(1, 1, 4'd0, 16'h2222, 0);
        #3;
        rst = 1'b1;
        mreset(0);
        mreset(1);
        #1;
        check("arst_out0", 32'(dq[0][0]), 32'd0);
        check("arst_valid", 32'(ov[0]), 32'd0);
        check_all();
        step();
        #2;
        rst = 1'b0;
        drive(1, 1, 4'd0, 16'h3333, 0);
        step();
        check("post_rst_out0", 32'(dq[0][0]), 32'h3333);
        check("post_rst_ptr", 32'(wp[0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
